// File: rtl/adc_conv_sequencer_if.sv
// Bundles the configuration, trigger, ADC pins and result signals of the conversion sequencer.
// Purely combinational wiring; no latency of its own.
// No backpressure: trigger is a fire-and-forget pulse, results are a one-cycle valid strobe.
interface adc_conv_sequencer_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16
);
    logic                       cfg_enable;
    logic [7:0]                 cfg_trig_div;
    logic [3:0]                 cfg_sck_half;
    logic                       trigger;
    logic                       adc_cnv;
    logic                       adc_sck;
    logic [NUM_CH-1:0]          adc_sdo;
    logic [NUM_CH*DATA_W-1:0]   data_out;
    logic                       data_valid;
    logic                       busy;
    logic [15:0]                overrun_cnt;

    // Environment side: register file, PWM sync source and the ADC data pins.
    modport master (
        output cfg_enable, cfg_trig_div, cfg_sck_half, trigger, adc_sdo,
        input  adc_cnv, adc_sck, data_out, data_valid, busy, overrun_cnt
    );

    // Sequencer side.
    modport slave (
        input  cfg_enable, cfg_trig_div, cfg_sck_half, trigger, adc_sdo,
        output adc_cnv, adc_sck, data_out, data_valid, busy, overrun_cnt
    );
endinterface

// File: rtl/adc_conv_sequencer.sv
// Runs one CNV / wait / serial-shift / latch cycle on a multi-lane ADC per accepted trigger.
// Latency: trigger in cycle T -> data_valid in T+1+CNV_CYCLES+CONV_WAIT+2*H*DATA_W.
// No backpressure: triggers arriving while busy are dropped and counted in overrun_cnt.
module adc_conv_sequencer #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 16,
    parameter int CNV_CYCLES = 4,
    parameter int CONV_WAIT  = 50
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    adc_conv_sequencer_if.slave   bus
);

    localparam int TMR_MAX = (CNV_CYCLES > CONV_WAIT) ? CNV_CYCLES : CONV_WAIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     div_q, div_d;
    logic [TMR_W-1:0]               tmr_q;
    logic [3:0]                     h_q;
    logic [3:0]                     ph_q;
    logic                           sck_q;
    logic [BIT_W-1:0]               bit_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  sh_q;
    logic [NUM_CH*DATA_W-1:0]       dout_q;
    logic [15:0]                    ovr_q;

    logic trig_idle;
    logic div_hit;
    logic ph_end;
    logic last_bit;
    logic cnv_done;
    logic wait_done;

    assign trig_idle = bus.trigger && bus.cfg_enable && (state_q == S_IDLE);
    assign div_hit   = (div_q >= bus.cfg_trig_div);
    assign ph_end    = (ph_q == (h_q - 4'd1));
    assign last_bit  = (bit_q == BIT_W'(DATA_W - 1));
    assign cnv_done  = (tmr_q == TMR_W'(CNV_CYCLES - 1));
    assign wait_done = (tmr_q == TMR_W'(CONV_WAIT - 1));

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; SHIFT ends at the close of the last high SCK phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trig_idle && div_hit)          state_d = S_CNV;
            S_CNV:   if (cnv_done)                      state_d = S_WAIT;
            S_WAIT:  if (wait_done)                     state_d = S_SHIFT;
            S_SHIFT: if (sck_q && ph_end && last_bit)   state_d = S_LATCH;
            S_LATCH:                                    state_d = S_IDLE;
            default:                                    state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        bus.adc_cnv    = 1'b0;
        bus.data_valid = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        case (state_q)
            S_CNV:   bus.adc_cnv    = 1'b1;
            S_LATCH: bus.data_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.adc_sck     = sck_q;
    assign bus.data_out    = dout_q;
    assign bus.overrun_cnt = ovr_q;

    // Trigger divider: only advances on enabled triggers seen in IDLE; clears when it fires.
    always_comb begin
        div_d = div_q;
        if (trig_idle) div_d = div_hit ? 8'd0 : (div_q + 8'd1);
    end

    // Divider register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) div_q <= 8'd0;
        else          div_q <= div_d;
    end

    // Dwell timer for CNV and WAIT; restarts on every state change.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)                                           tmr_q <= '0;
        else if (state_d != state_q)                            tmr_q <= '0;
        else if ((state_q == S_CNV) || (state_q == S_WAIT))     tmr_q <= tmr_q + TMR_W'(1);
        else                                                    tmr_q <= '0;
    end

    // Freeze the SCK half-period at conversion start so later cfg writes cannot disturb it.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            h_q <= 4'd1;
        else if ((state_q == S_IDLE) && (state_d == S_CNV))
            h_q <= (bus.cfg_sck_half == 4'd0) ? 4'd1 : bus.cfg_sck_half;
    end

    // SCK generator and shifter: sample every lane on the edge that raises SCK.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ph_q  <= 4'd0;
            sck_q <= 1'b0;
            bit_q <= '0;
            sh_q  <= '0;
        end else if (state_q != S_SHIFT) begin
            ph_q  <= 4'd0;
            sck_q <= 1'b0;
            bit_q <= '0;
        end else if (!ph_end) begin
            ph_q <= ph_q + 4'd1;
        end else begin
            ph_q <= 4'd0;
            if (!sck_q) begin
                sck_q <= 1'b1;
                for (int k = 0; k < NUM_CH; k++)
                    sh_q[k] <= {sh_q[k][DATA_W-2:0], bus.adc_sdo[k]};
            end else begin
                sck_q <= 1'b0;
                bit_q <= bit_q + BIT_W'(1);
            end
        end
    end

    // Result register loads as LATCH is entered so data_out is already new while data_valid is high.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)                                           dout_q <= '0;
        else if ((state_q == S_SHIFT) && (state_d == S_LATCH))  dout_q <= sh_q;
    end

    // Saturating count of triggers dropped because a conversion was in flight.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            ovr_q <= 16'd0;
        else if (bus.trigger && (state_q != S_IDLE) && (ovr_q != 16'hFFFF))
            ovr_q <= ovr_q + 16'd1;
    end

endmodule
